// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and types for the memory-access stage.
//   - bus widths between EXM and the memory stage
//   - bit_width access-size encodings
//   - FSM state encodings (2-bit)
//   - es_to_ms_t: field view of es_to_ms_bus
package mem_stage_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned ES_TO_MS_BUS_WD = 103;
    localparam int unsigned MS_TO_ES_BUS_WD = 34;

    // Access size encodings; any other value behaves as a word access.
    localparam logic [3:0] BW_BYTE = 4'b0001;
    localparam logic [3:0] BW_HALF = 4'b0011;
    localparam logic [3:0] BW_WORD = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Field order matches the packed bus, MSB first.
    typedef struct packed {
        logic [31:0] addr;
        logic        is_unsigned;
        logic        mem_we;
        logic        mem_re;
        logic [3:0]  bit_width;
        logic [31:0] wdata;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-cache request/response port.
//   master (mem_stage): dc_req_valid, dc_req_we, dc_req_addr, dc_req_wstrb,
//                       dc_req_wdata out; dc_req_ready, dc_resp_valid,
//                       dc_resp_rdata in.
//   slave  (cache):     the mirror image.
// Handshake: a request transfers on a clock edge where dc_req_valid and
// dc_req_ready are both high; once valid is raised, it and every request
// field stay constant until that edge. dc_resp_valid has no ready: the
// response is a single-cycle pulse that the master must take when it arrives.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dc_req_valid;
    logic            dc_req_ready;
    logic            dc_req_we;
    logic [XLEN-1:0] dc_req_addr;
    logic [3:0]      dc_req_wstrb;
    logic [XLEN-1:0] dc_req_wdata;
    logic            dc_resp_valid;
    logic [XLEN-1:0] dc_resp_rdata;

    modport master (
        output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wstrb, dc_req_wdata,
        input  dc_req_ready, dc_resp_valid, dc_resp_rdata
    );

    modport slave (
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wstrb, dc_req_wdata,
        output dc_req_ready, dc_resp_valid, dc_resp_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data shaping.
//   raw         in  32  word returned by the data cache
//   addr_lo     in  2   byte offset of the access
//   bit_width   in  4   access size (byte / half / anything else = word)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  lane-selected, extended load value
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      addr_lo,
    input  logic [3:0]      bit_width,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = raw[7:0];
        case (addr_lo)
            2'd0: byte_lane = raw[7:0];
            2'd1: byte_lane = raw[15:8];
            2'd2: byte_lane = raw[23:16];
            2'd3: byte_lane = raw[31:24];
            default: byte_lane = raw[7:0];
        endcase
        // Halves are always 2-byte aligned here; addr_lo[0] is a misalignment.
        half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];

        if (bit_width == BW_BYTE) begin
            result = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
        end else if (bit_width == BW_HALF) begin
            result = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        end else begin
            result = raw;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind EXM.
//   clk, reset    clock; synchronous active-high reset
//   es_to_ms_bus  in  103 {addr, is_unsigned, mem_we, mem_re, bit_width, wdata, pc}
//   ms_advance    in  1   EXM instruction leaves the stage this cycle
//   ms_to_es_bus  out 34  {excp_ale, dcache_ok, mem_result}
//   dc            master side of the data-cache port (mem_stage_if)
//   dbg_state     out 2   current FSM state
// One request is outstanding at most. EXM stalls while dcache_ok is low and
// keeps es_to_ms_bus stable, so the request fields are driven straight from
// the bus and stay stable across REQ.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ms_advance,
    output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
    mem_stage_if.master                dc,
    output logic [1:0]                 dbg_state
);

    es_to_ms_t       req;
    logic            is_byte, is_half, is_word;
    logic            mem_op, mis, excp_ale, go;
    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] ld_data_r, ld_ext, mem_result;
    logic            dcache_ok, req_valid, accept;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] wdata;
    logic            unused_pc;

    assign req       = es_to_ms_t'(es_to_ms_bus);
    assign unused_pc = ^req.pc;

    assign is_byte  = (req.bit_width == BW_BYTE);
    assign is_half  = (req.bit_width == BW_HALF);
    assign is_word  = !is_byte && !is_half;
    assign mem_op   = req.mem_we | req.mem_re;
    assign mis      = (is_half & req.addr[0]) | (is_word & (|req.addr[1:0]));
    assign excp_ale = mem_op & mis;
    assign go       = mem_op & ~mis;

    load_align u_load_align (
        .raw         (dc.dc_resp_rdata),
        .addr_lo     (req.addr[1:0]),
        .bit_width   (req.bit_width),
        .is_unsigned (req.is_unsigned),
        .result      (ld_ext)
    );

    always_comb begin
        state_nxt  = state;
        req_valid  = 1'b0;
        dcache_ok  = 1'b0;
        mem_result = '0;
        case (state)
            ST_IDLE: begin
                if (!go) begin
                    dcache_ok = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    if (dc.dc_req_ready) state_nxt = req.mem_we ? ST_DONE : ST_WAIT;
                    else                 state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (dc.dc_req_ready) state_nxt = req.mem_we ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (dc.dc_resp_valid) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                dcache_ok  = 1'b1;
                mem_result = ld_data_r;
                if (ms_advance) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = req_valid & dc.dc_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ld_data_r <= '0;
        end else begin
            state <= state_nxt;
            // Stores report 0 in DONE, so clear any older load value on acceptance.
            if (accept && req.mem_we) begin
                ld_data_r <= '0;
            end else if (state == ST_WAIT && dc.dc_resp_valid) begin
                ld_data_r <= ld_ext;
            end
        end
    end

    // Store lane replication and byte strobes.
    always_comb begin
        wstrb = 4'b0000;
        wdata = req.wdata;
        if (req.mem_we) begin
            if (is_byte) begin
                wdata = {4{req.wdata[7:0]}};
                wstrb = 4'b0001 << req.addr[1:0];
            end else if (is_half) begin
                wdata = {2{req.wdata[15:0]}};
                wstrb = 4'b0011 << req.addr[1:0];
            end else begin
                wstrb = 4'b1111;
            end
        end
    end

    assign dc.dc_req_valid = req_valid;
    assign dc.dc_req_we    = req.mem_we;
    assign dc.dc_req_addr  = {req.addr[31:2], 2'b00};
    assign dc.dc_req_wstrb = wstrb;
    assign dc.dc_req_wdata = wdata;

    assign ms_to_es_bus = {excp_ale, dcache_ok, mem_result};
    assign dbg_state    = state;

endmodule
